// File: rtl/man_jump_if.sv
// man_jump_if: signal bundle between the game state machine / renderer and man_jump.
//   state         game state code driven by the game FSM
//   i_squeeze_man squeeze count from the squeeze stage
//   o_busy        jump in flight (FLY or LAND)
//   o_dx          horizontal offset from the take-off point
//   o_dy          height above the take-off line
//   o_land        one-cycle landing pulse
//   o_dist        latched jump distance, valid with o_land and held afterwards
// Modports: master = game side (drives state/squeeze), slave = man_jump.
interface man_jump_if #(
  parameter int unsigned SQZ_W = 8,
  parameter int unsigned H_W   = 10
);
  logic [2:0]       state;
  logic [SQZ_W-1:0] i_squeeze_man;
  logic             o_busy;
  logic [SQZ_W-1:0] o_dx;
  logic [H_W-1:0]   o_dy;
  logic             o_land;
  logic [SQZ_W-1:0] o_dist;

  modport master (
    output state,
    output i_squeeze_man,
    input  o_busy,
    input  o_dx,
    input  o_dy,
    input  o_land,
    input  o_dist
  );

  modport slave (
    input  state,
    input  i_squeeze_man,
    output o_busy,
    output o_dx,
    output o_dy,
    output o_land,
    output o_dist
  );
endinterface

// File: rtl/man_jump.sv
// man_jump: jump-trajectory generator for the player figure.
// On a fresh entry into ST_JUMP it latches the squeeze count, flies a discrete parabola over
// N_STEPS motion ticks (one tick every TICK_DIV clocks) and pulses o_land with the distance.
// Ports:
//   clk_machine  main clock
//   rst_machine  asynchronous reset, active-low
//   jmp_io       man_jump_if.slave: state/i_squeeze_man in; o_busy/o_dx/o_dy/o_land/o_dist out
module man_jump #(
  parameter int unsigned SQZ_W    = 8,
  parameter int unsigned H_W      = 10,
  parameter int unsigned N_STEPS  = 32,
  parameter int unsigned TICK_DIV = 250000,
  parameter logic [2:0]  ST_JUMP  = 3'd4
) (
  input logic       clk_machine,
  input logic       rst_machine,
  man_jump_if.slave jmp_io
);

  localparam int unsigned LogN = $clog2(N_STEPS);
  localparam int unsigned TW   = LogN + 1;
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned AccW = SQZ_W + LogN;

  localparam logic [TW-1:0]          TLast   = TW'(N_STEPS - 1);
  localparam logic [DivW-1:0]        DivLast = DivW'(TICK_DIV - 1);
  localparam logic signed [H_W:0]    VyInit  = (H_W + 1)'(N_STEPS - 1);
  localparam logic signed [H_W:0]    VyStep  = (H_W + 1)'(2);

  typedef enum logic [1:0] {StIdle, StFly, StLand} st_e;

  st_e                    st_q, st_d;
  logic [2:0]             state_q;
  logic [SQZ_W-1:0]       sq_q, sq_d;
  logic [TW-1:0]          t_q, t_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [H_W-1:0]         h_q, h_d;
  logic signed [H_W:0]    vy_q, vy_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [SQZ_W-1:0]       dist_q, dist_d;

  logic launch;
  logic tick;

  // Edge-detect on the game state so a held ST_JUMP launches only once.
  assign launch = (jmp_io.state == ST_JUMP) && (state_q != ST_JUMP);
  assign tick   = (div_q == DivLast);

  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      st_q    <= StIdle;
      state_q <= 3'd0;
      sq_q    <= '0;
      t_q     <= '0;
      div_q   <= '0;
      h_q     <= '0;
      vy_q    <= '0;
      acc_q   <= '0;
      dist_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= jmp_io.state;
      sq_q    <= sq_d;
      t_q     <= t_d;
      div_q   <= div_d;
      h_q     <= h_d;
      vy_q    <= vy_d;
      acc_q   <= acc_d;
      dist_q  <= dist_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    sq_d   = sq_q;
    t_d    = t_q;
    div_d  = div_q;
    h_d    = h_q;
    vy_d   = vy_q;
    acc_d  = acc_q;
    dist_d = dist_q;

    unique case (st_q)
      StIdle: begin
        if (launch) begin
          st_d  = StFly;
          sq_d  = jmp_io.i_squeeze_man;
          t_d   = '0;
          div_d = '0;
          h_d   = '0;
          acc_d = '0;
          vy_d  = VyInit;
        end
      end
      StFly: begin
        if (tick) begin
          div_d = '0;
          t_d   = t_q + TW'(1);
          // h + vy never leaves [0, N^2/4], so a modulo-2^H_W add of vy's low bits is exact.
          h_d   = h_q + vy_q[H_W-1:0];
          vy_d  = vy_q - VyStep;
          acc_d = acc_q + AccW'(sq_q);
          if (t_q == TLast) begin
            st_d   = StLand;
            dist_d = sq_q;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StLand: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  assign jmp_io.o_busy = (st_q != StIdle);
  assign jmp_io.o_land = (st_q == StLand);
  // acc = sq*t, so dropping log2(N) bits gives sq*t/N: monotonic and exactly sq at t=N.
  assign jmp_io.o_dx   = acc_q[AccW-1:LogN];
  assign jmp_io.o_dy   = h_q;
  assign jmp_io.o_dist = dist_q;

endmodule

// File: tb/tb_man_jump.sv
`timescale 1ns/1ps
module tb_man_jump;

  localparam int SQZ_W    = 8;
  localparam int H_W      = 10;
  localparam int N_STEPS  = 32;
  localparam int TICK_DIV = 4;
  localparam int FLY_CYC  = N_STEPS * TICK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  man_jump_if #(.SQZ_W(SQZ_W), .H_W(H_W)) jif ();

  man_jump #(
    .SQZ_W   (SQZ_W),
    .H_W     (H_W),
    .N_STEPS (N_STEPS),
    .TICK_DIV(TICK_DIV),
    .ST_JUMP (3'd4)
  ) dut (
    .clk_machine(clk),
    .rst_machine(rst_n),
    .jmp_io     (jif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SQZ_W-1:0] dx;
    logic [H_W-1:0]   dy;
  } tick_t;

  tick_t            tick_q[$];
  logic [SQZ_W-1:0] land_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [H_W-1:0] model_dy(input int k);
    return H_W'(k * (N_STEPS - k));
  endfunction

  function automatic logic [SQZ_W-1:0] model_dx(input int sq, input int k);
    return SQZ_W'((sq * k) / N_STEPS);
  endfunction

  task automatic push_expect(input logic [SQZ_W-1:0] sq);
    tick_t e;
    for (int k = 1; k <= N_STEPS; k++) begin
      e.dx = model_dx(int'(sq), k);
      e.dy = model_dy(k);
      tick_q.push_back(e);
    end
    land_q.push_back(sq);
  endtask

  task automatic clear_sb();
    tick_q.delete();
    land_q.delete();
  endtask

  // Called at a negedge; the launch edge E0 is the second posedge after the call.
  task automatic start_jump(input logic [SQZ_W-1:0] sq);
    jif.state = 3'd3;
    @(negedge clk);
    jif.i_squeeze_man = sq;
    jif.state         = 3'd4;
    push_expect(sq);
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    jif.state         = 3'd3;
    jif.i_squeeze_man = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (jif.o_busy !== 1'b0 || jif.o_land !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got busy=%b land=%b want 0 0", jif.o_busy, jif.o_land);
    end
    n_cmp++;
    if (jif.o_dx !== '0 || jif.o_dy !== '0 || jif.o_dist !== '0) begin
      n_bad++;
      $display("FAIL reset_values got dx=%0d dy=%0d dist=%0d want 0 0 0",
               jif.o_dx, jif.o_dy, jif.o_dist);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (jif.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle got busy=%b want 0", jif.o_busy);
    end
  endtask

  task automatic test_basic();
    tick_t            e;
    logic [SQZ_W-1:0] d;
    int k = 0, busy = 0, lands = 0;
    clear_sb();
    start_jump(8'd100);
    for (int i = 0; i < FLY_CYC + 12; i++) begin
      @(negedge clk);
      if (jif.o_busy === 1'b1) busy++;
      if (i > 0 && i % TICK_DIV == 0 && i <= FLY_CYC) begin
        k++;
        n_cmp++;
        if (tick_q.size() == 0) begin
          n_bad++;
          $display("FAIL basic_tick k=%0d got extra tick want none", k);
        end else begin
          e = tick_q.pop_front();
          if (jif.o_dx !== e.dx || jif.o_dy !== e.dy) begin
            n_bad++;
            $display("FAIL basic_tick k=%0d got dx=%0d dy=%0d want dx=%0d dy=%0d",
                     k, jif.o_dx, jif.o_dy, e.dx, e.dy);
          end
        end
        if (k == 1 || k == 16 || k == 32) begin
          n_cmp++;
          if ((k == 1 && jif.o_dy !== 10'd31) ||
              (k == 16 && (jif.o_dy !== 10'd256 || jif.o_dx !== 8'd50)) ||
              (k == 32 && (jif.o_dy !== 10'd0 || jif.o_dx !== 8'd100))) begin
            n_bad++;
            $display("FAIL basic_anchor k=%0d got dx=%0d dy=%0d", k, jif.o_dx, jif.o_dy);
          end
        end
      end
      if (jif.o_land === 1'b1) begin
        lands++;
        n_cmp++;
        if (land_q.size() == 0) begin
          n_bad++;
          $display("FAIL basic_land got unexpected pulse at %0d want none", i);
        end else begin
          d = land_q.pop_front();
          if (i != FLY_CYC || jif.o_dist !== d) begin
            n_bad++;
            $display("FAIL basic_land got at=%0d dist=%0d want at=%0d dist=%0d",
                     i, jif.o_dist, FLY_CYC, d);
          end
        end
      end
    end
    n_cmp++;
    if (busy != FLY_CYC + 1 || lands != 1 || tick_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_counts got busy=%0d lands=%0d left=%0d want %0d 1 0",
               busy, lands, tick_q.size(), FLY_CYC + 1);
    end
    n_cmp++;
    if (jif.o_dx !== 8'd100 || jif.o_dy !== 10'd0 || jif.o_dist !== 8'd100) begin
      n_bad++;
      $display("FAIL basic_hold got dx=%0d dy=%0d dist=%0d want 100 0 100",
               jif.o_dx, jif.o_dy, jif.o_dist);
    end
  endtask

  task automatic test_zero_squeeze();
    tick_t            e;
    logic [SQZ_W-1:0] d;
    logic [H_W-1:0]   peak = '0;
    int k = 0, lands = 0, dx_bad = 0;
    clear_sb();
    start_jump(8'd0);
    for (int i = 0; i < FLY_CYC + 8; i++) begin
      @(negedge clk);
      if (jif.o_dx !== '0) dx_bad++;
      if (jif.o_dy > peak) peak = jif.o_dy;
      if (i > 0 && i % TICK_DIV == 0 && i <= FLY_CYC) begin
        k++;
        n_cmp++;
        if (tick_q.size() == 0) begin
          n_bad++;
          $display("FAIL zero_tick k=%0d got extra tick want none", k);
        end else begin
          e = tick_q.pop_front();
          if (jif.o_dx !== e.dx || jif.o_dy !== e.dy) begin
            n_bad++;
            $display("FAIL zero_tick k=%0d got dx=%0d dy=%0d want dx=%0d dy=%0d",
                     k, jif.o_dx, jif.o_dy, e.dx, e.dy);
          end
        end
      end
      if (jif.o_land === 1'b1) begin
        lands++;
        n_cmp++;
        d = (land_q.size() != 0) ? land_q.pop_front() : 8'hxx;
        if (i != FLY_CYC || jif.o_dist !== d) begin
          n_bad++;
          $display("FAIL zero_land got at=%0d dist=%0d want at=%0d dist=%0d",
                   i, jif.o_dist, FLY_CYC, d);
        end
      end
    end
    n_cmp++;
    if (dx_bad != 0 || peak !== 10'd256 || lands != 1) begin
      n_bad++;
      $display("FAIL zero_summary got dx_nonzero=%0d peak=%0d lands=%0d want 0 256 1",
               dx_bad, peak, lands);
    end
  endtask

  task automatic test_max_value();
    tick_t            e;
    logic [SQZ_W-1:0] d;
    logic [SQZ_W-1:0] prev = '0;
    int k = 0, lands = 0, drops = 0;
    clear_sb();
    start_jump(8'd255);
    for (int i = 0; i < FLY_CYC + 8; i++) begin
      @(negedge clk);
      if (jif.o_dx < prev) drops++;
      prev = jif.o_dx;
      if (i > 0 && i % TICK_DIV == 0 && i <= FLY_CYC) begin
        k++;
        n_cmp++;
        if (tick_q.size() == 0) begin
          n_bad++;
          $display("FAIL max_tick k=%0d got extra tick want none", k);
        end else begin
          e = tick_q.pop_front();
          if (jif.o_dx !== e.dx || jif.o_dy !== e.dy) begin
            n_bad++;
            $display("FAIL max_tick k=%0d got dx=%0d dy=%0d want dx=%0d dy=%0d",
                     k, jif.o_dx, jif.o_dy, e.dx, e.dy);
          end
        end
      end
      if (jif.o_land === 1'b1) begin
        lands++;
        n_cmp++;
        d = (land_q.size() != 0) ? land_q.pop_front() : 8'hxx;
        if (i != FLY_CYC || jif.o_dist !== d) begin
          n_bad++;
          $display("FAIL max_land got at=%0d dist=%0d want at=%0d dist=%0d",
                   i, jif.o_dist, FLY_CYC, d);
        end
      end
    end
    n_cmp++;
    if (drops != 0 || jif.o_dx !== 8'd255 || lands != 1) begin
      n_bad++;
      $display("FAIL max_summary got drops=%0d dx=%0d lands=%0d want 0 255 1",
               drops, jif.o_dx, lands);
    end
  endtask

  task automatic test_isolation();
    tick_t            e;
    logic [SQZ_W-1:0] d;
    int k = 0, busy = 0, lands = 0;
    clear_sb();
    start_jump(8'd100);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (jif.o_busy === 1'b1) busy++;
      if (i > 0 && i % TICK_DIV == 0 && i <= FLY_CYC) begin
        k++;
        n_cmp++;
        if (tick_q.size() == 0) begin
          n_bad++;
          $display("FAIL iso_tick k=%0d got extra tick want none", k);
        end else begin
          e = tick_q.pop_front();
          if (jif.o_dx !== e.dx || jif.o_dy !== e.dy) begin
            n_bad++;
            $display("FAIL iso_tick k=%0d got dx=%0d dy=%0d want dx=%0d dy=%0d",
                     k, jif.o_dx, jif.o_dy, e.dx, e.dy);
          end
        end
      end
      if (jif.o_land === 1'b1) begin
        lands++;
        n_cmp++;
        d = (land_q.size() != 0) ? land_q.pop_front() : 8'hxx;
        if (i != FLY_CYC || jif.o_dist !== d) begin
          n_bad++;
          $display("FAIL iso_land got at=%0d dist=%0d want at=%0d dist=%0d",
                   i, jif.o_dist, FLY_CYC, d);
        end
      end
      if (i == 5 * TICK_DIV) jif.i_squeeze_man = 8'd7;
    end
    n_cmp++;
    if (busy != FLY_CYC + 1 || lands != 1 || jif.o_dist !== 8'd100) begin
      n_bad++;
      $display("FAIL iso_summary got busy=%0d lands=%0d dist=%0d want %0d 1 100",
               busy, lands, jif.o_dist, FLY_CYC + 1);
    end
  endtask

  task automatic test_back_to_back();
    tick_t            e;
    logic [SQZ_W-1:0] d;
    int k = 0, busy = 0, lands = 0, rel;
    int second = FLY_CYC + 2;
    clear_sb();
    start_jump(8'd50);
    for (int i = 0; i < second + FLY_CYC + 10; i++) begin
      @(negedge clk);
      if (jif.o_busy === 1'b1) busy++;
      rel = (i < second) ? i : i - second;
      if (rel > 0 && rel % TICK_DIV == 0 && rel <= FLY_CYC) begin
        k++;
        n_cmp++;
        if (tick_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_tick n=%0d got extra tick want none", k);
        end else begin
          e = tick_q.pop_front();
          if (jif.o_dx !== e.dx || jif.o_dy !== e.dy) begin
            n_bad++;
            $display("FAIL b2b_tick n=%0d got dx=%0d dy=%0d want dx=%0d dy=%0d",
                     k, jif.o_dx, jif.o_dy, e.dx, e.dy);
          end
        end
      end
      if (jif.o_land === 1'b1) begin
        lands++;
        n_cmp++;
        d = (land_q.size() != 0) ? land_q.pop_front() : 8'hxx;
        if (rel != FLY_CYC || jif.o_dist !== d) begin
          n_bad++;
          $display("FAIL b2b_land got at=%0d dist=%0d want rel=%0d dist=%0d",
                   i, jif.o_dist, FLY_CYC, d);
        end
      end
      if (i == FLY_CYC + 1) begin
        n_cmp++;
        if (jif.o_busy !== 1'b0 || jif.o_land !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_gap got busy=%b land=%b want 0 0", jif.o_busy, jif.o_land);
        end
      end
      // Toggle during flight must be ignored; toggle right after landing relaunches.
      if (i == 40) jif.state = 3'd3;
      if (i == 41) jif.state = 3'd4;
      if (i == FLY_CYC) jif.state = 3'd3;
      if (i == FLY_CYC + 1) begin
        jif.i_squeeze_man = 8'd60;
        jif.state         = 3'd4;
        push_expect(8'd60);
      end
    end
    n_cmp++;
    if (busy != 2 * (FLY_CYC + 1) || lands != 2 || tick_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_counts got busy=%0d lands=%0d left=%0d want %0d 2 0",
               busy, lands, tick_q.size(), 2 * (FLY_CYC + 1));
    end
  endtask

  task automatic test_reset_mid_flight();
    int busy = 0, lands = 0;
    clear_sb();
    start_jump(8'd100);
    for (int i = 0; i <= 10 * TICK_DIV; i++) @(negedge clk);
    n_cmp++;
    if (jif.o_busy !== 1'b1 || jif.o_dx !== model_dx(100, 10) || jif.o_dy !== model_dy(10)) begin
      n_bad++;
      $display("FAIL rstmid_pre got busy=%b dx=%0d dy=%0d want 1 %0d %0d",
               jif.o_busy, jif.o_dx, jif.o_dy, model_dx(100, 10), model_dy(10));
    end
    rst_n     = 1'b0;
    jif.state = 3'd3;
    #1;
    n_cmp++;
    if (jif.o_busy !== 1'b0 || jif.o_land !== 1'b0 || jif.o_dx !== '0 ||
        jif.o_dy !== '0 || jif.o_dist !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear got busy=%b land=%b dx=%0d dy=%0d dist=%0d want all 0",
               jif.o_busy, jif.o_land, jif.o_dx, jif.o_dy, jif.o_dist);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (jif.o_busy === 1'b1) busy++;
      if (jif.o_land === 1'b1) lands++;
    end
    n_cmp++;
    if (busy != 0 || lands != 0) begin
      n_bad++;
      $display("FAIL rstmid_after got busy=%0d lands=%0d want 0 0", busy, lands);
    end
    clear_sb();
  endtask

  initial begin
    jif.state         = 3'd3;
    jif.i_squeeze_man = '0;
    test_reset();
    test_basic();
    test_zero_squeeze();
    test_max_value();
    test_isolation();
    test_back_to_back();
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
